uart_rx_v2: RTL and testbench
=============================

Name: uart_rx_v2

Overview:
Second-generation UART receiver. Adds the following to the existing receiver:
- Parametrised data width.
- 3-sample majority-vote bit detection.
- Optional second stop bit.
- Valid/ready output handshake with overrun detection.
- Input synchroniser.

It sits between the pad-side serial line and the byte-consuming logic, in the same position as the current UART_RX.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line; idles high.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits.
- Prescale  in  PRESCALE_WIDTH  CLK cycles per bit; legal values are even numbers 8..32.
- Data_Ready  in  1  consumer accepts P_DATA.
- P_DATA  out  DATA_WIDTH  received word, LSB first on the line.
- Data_Valid  out  1  P_DATA holds an unread word.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: a stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good frame dropped.
- busy  out  1  frame in progress.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM goes to IDLE; counters clear.
  - P_DATA=0; Data_Valid, par_err, stp_err, overrun and busy all 0.
  - Synchroniser flops set to 1.
  - Reset mid-frame discards the partial frame with no pulses.
- Synchroniser: RX_IN passes through 2 flops (rx_s). All timing below refers to rx_s.
- Counters:
  - edge_cnt runs 0..Prescale-1 per bit; bit_cnt counts bits within a state.
  - Bit sampling: rx_s is captured at edge_cnt = P/2-1, P/2 and P/2+1 (P = Prescale). The bit value is the majority of the 3 captures, resolved at edge_cnt = P/2+1 (the "decision cycle").
- FSM:
  - IDLE: a falling edge on rx_s sets edge_cnt=0, busy=1 and enters START.
  - START: at the decision cycle, majority 1 means a glitch: return to IDLE, no outputs. Majority 0 continues to DATA at the bit boundary.
  - DATA: DATA_WIDTH bits are shifted LSB first. Then go to PARITY if PAR_EN, otherwise STOP.
  - PARITY: capture the parity bit. Expected value is ^data for even, ~^data for odd.
  - STOP: 1 bit, or 2 bits if STOP2. Any stop decision of 0 flags a stop error. At the decision cycle of the final stop bit, the frame completes and the FSM returns to IDLE in the next cycle with busy=0. A start edge inside the remaining half bit is therefore accepted.
- Completion cycle C = the final stop decision cycle. In cycle C+1:
  - par_err pulses if there was a parity mismatch; stp_err pulses if there was a stop error. Both may pulse together.
  - An errored frame never loads P_DATA or sets Data_Valid.
  - A good frame with Data_Valid=0 (or Data_Valid=1 and Data_Ready=1 in cycle C) loads P_DATA and sets Data_Valid=1.
  - A good frame with Data_Valid=1 and Data_Ready=0 in cycle C pulses overrun. The new word is dropped and P_DATA is unchanged.
- Handshake: Data_Valid stays high until a CLK edge with Data_Ready=1, then clears the next cycle unless a new word loads on that edge. P_DATA holds its value after Data_Valid clears.
- Configuration: PAR_EN, PAR_TYP, STOP2 and Prescale are sampled only in IDLE. Changes while busy=1 do not affect the current frame.
- Illegal Prescale values give undefined timing but must not lock up the FSM; the FSM returns to IDLE on frame end.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - Output port brk (1 bit) exists.
  - A frame whose start, all data, parity (if enabled) and first stop decision are all 0 is a break. brk pulses in C+1 instead of stp_err/par_err.
  - The FSM then enters BRK_WAIT and stays there until rx_s=1 for one full bit time (Prescale cycles), then returns to IDLE. busy stays 1 in BRK_WAIT.
- Undefined:
  - No brk port and no BRK_WAIT state.
  - Such a frame is an ordinary framing error: stp_err pulses (plus par_err if the parity mismatches).
  - The FSM returns to IDLE immediately, as in normal completion.

Test Plan:
1. P=8, PAR_EN=0, STOP2=0, line sends 0x99 then 0x55, Data_Ready=1. Required: two Data_Valid with P_DATA 0x99 then 0x55; no error pulses.
2. P=8, PAR_EN=1, PAR_TYP=0, 0x99 with parity bit 1 (wrong). Required: par_err one-cycle pulse; Data_Valid stays 0. Next frame 0x55 with parity 0 gives Data_Valid, P_DATA=0x55.
3. P=16, STOP2=1, 0xA5 with second stop bit 0. Required: stp_err pulse, no Data_Valid. Then 0x3C with good stops gives P_DATA=0x3C.
4. P=8, Data_Ready=0, send 0x12 then 0x34. Required: P_DATA=0x12 with Data_Valid=1, overrun pulses at the 2nd completion, P_DATA still 0x12. Raising Data_Ready clears Data_Valid one cycle later.
5. Glitches: a 2-cycle low glitch on RX_IN (P=8) gives no busy beyond START and no outputs. A single-cycle 1 spike mid data bit (value 0) is filtered by majority, so the word is correct.
6. RST low mid-DATA: all outputs 0 immediately. After release, frame 0xF0 is received correctly. With UART_RX_BREAK_DET_EN, 12 bit-times low give a brk pulse, and there is no reception until the line is high for 8 cycles.

Source files
------------

// File: rtl/uart_rx_v2.sv
// uart_rx_v2: oversampling UART receiver with 3-sample majority vote, parity, 1/2 stop bits and valid/ready output.
// Define UART_RX_BREAK_DET_EN to add the brk output and the BRK_WAIT state.
module uart_rx_v2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      Data_Ready,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      overrun,
`ifdef UART_RX_BREAK_DET_EN
    output logic                      brk,
`endif
    output logic                      busy
);
`ifdef UART_RX_BREAK_DET_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
    state_t state;
    logic rx_m, rx_s, rx_p;
    logic [PRESCALE_WIDTH-1:0] edge_cnt, pres_r, half, last;
    logic [3:0] bit_cnt;
    logic par_en_r, par_typ_r, stop2_r;
    logic s0, s1, par_bit, stp_bad;
    logic [DATA_WIDTH-1:0] shreg;
    logic dec, bound, maj, last_bit, final_stop, stp_now, par_bad, good, load;
`ifdef UART_RX_BREAK_DET_EN
    logic all_zero, brk_now;
`endif

    always_comb begin
        half       = pres_r >> 1;
        last       = pres_r - 1'b1;
        dec        = edge_cnt == half + 1'b1;
        bound      = edge_cnt == last;
        maj        = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        last_bit   = bit_cnt == 4'(DATA_WIDTH - 1);
        final_stop = bit_cnt == {3'b000, stop2_r};
        stp_now    = stp_bad | ~maj;
        par_bad    = par_en_r & (par_bit != (par_typ_r ? ~^shreg : ^shreg));
        good       = ~stp_now & ~par_bad;
        load       = ~Data_Valid | Data_Ready;
`ifdef UART_RX_BREAK_DET_EN
        // with two stop bits all_zero already holds the first stop decision
        brk_now    = all_zero & (stop2_r | ~maj);
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_p       <= 1'b1;
            edge_cnt   <= '0;
            pres_r     <= PRESCALE_WIDTH'(8);
            bit_cnt    <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            stop2_r    <= 1'b0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            par_bit    <= 1'b0;
            stp_bad    <= 1'b0;
            shreg      <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk        <= 1'b0;
            all_zero   <= 1'b0;
`endif
        end else begin
            rx_m    <= RX_IN;
            rx_s    <= rx_m;
            rx_p    <= rx_s;
            par_err <= 1'b0;
            stp_err <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk     <= 1'b0;
            if (dec) all_zero <= all_zero & ~maj;
`endif
            if (Data_Ready) Data_Valid <= 1'b0;
            if (edge_cnt == half - 1'b1) s0 <= rx_s;
            if (edge_cnt == half) s1 <= rx_s;
            if (state != IDLE) edge_cnt <= bound ? '0 : edge_cnt + 1'b1;
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rx_p && !rx_s) begin
                        state     <= START;
                        busy      <= 1'b1;
                        par_en_r  <= PAR_EN;
                        par_typ_r <= PAR_TYP;
                        stop2_r   <= STOP2;
                        // short prescales would put the decision cycle past the bit end
                        pres_r    <= (Prescale < PRESCALE_WIDTH'(8)) ? PRESCALE_WIDTH'(8) : Prescale;
                        stp_bad   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero  <= 1'b1;
`endif
                    end
                end
                START: begin
                    if (dec && maj) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bound) state <= DATA;
                end
                DATA: begin
                    if (dec) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                    if (bound) begin
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                        if (last_bit) state <= par_en_r ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (dec) par_bit <= maj;
                    if (bound) state <= STOP;
                end
                STOP: begin
                    if (bound) bit_cnt <= bit_cnt + 1'b1;
                    if (dec && !final_stop) stp_bad <= stp_now;
                    if (dec && final_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        if (brk_now) begin
                            state    <= BRK_WAIT;
                            busy     <= 1'b1;
                            brk      <= 1'b1;
                            edge_cnt <= '0;
                        end else begin
`else
                        begin
`endif
                            par_err <= par_bad;
                            stp_err <= stp_now;
                            if (good && load) begin
                                P_DATA     <= shreg;
                                Data_Valid <= 1'b1;
                            end
                            if (good && !load) overrun <= 1'b1;
                        end
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                BRK_WAIT: begin
                    if (!rx_s) edge_cnt <= '0;
                    else if (bound) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_v2.sv
// tb_uart_rx_v2: directed frames with a scoreboard queue of expected output events and a negedge monitor.
module tb_uart_rx_v2;
    logic       TX_CLK_TB = 1'b0;
    logic       rst_n, rx_in, par_en, par_typ, stop2, data_ready;
    logic [5:0] prescale;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err, overrun, busy;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk;
`endif
    int checks = 0;
    int errors = 0;

    typedef struct packed {logic ld, pe, se, ov, bk; logic [7:0] d;} ev_t;
    ev_t q[$];
    ev_t obs, exp_ev;
    logic dv_p = 1'b0;
    logic dr_p = 1'b0;

    always #5 TX_CLK_TB = ~TX_CLK_TB;

    uart_rx_v2 dut (
        .CLK(TX_CLK_TB), .RST(rst_n), .RX_IN(rx_in), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(prescale), .Data_Ready(data_ready), .P_DATA(p_data),
        .Data_Valid(data_valid), .par_err(par_err), .stp_err(stp_err), .overrun(overrun),
`ifdef UART_RX_BREAK_DET_EN
        .brk(brk),
`endif
        .busy(busy)
    );

    always @(negedge TX_CLK_TB) begin
        obs.ld = data_valid && (!dv_p || dr_p);
        obs.pe = par_err;
        obs.se = stp_err;
        obs.ov = overrun;
`ifdef UART_RX_BREAK_DET_EN
        obs.bk = brk;
`else
        obs.bk = 1'b0;
`endif
        obs.d = p_data;
        if (obs.ld || obs.pe || obs.se || obs.ov || obs.bk) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %b_%h required none", obs[12:8], obs.d);
            end else begin
                exp_ev = q.pop_front();
                if (obs != exp_ev) begin
                    errors++;
                    $display("FAIL event ld/pe/se/ov/bk_data: got %b_%h required %b_%h",
                             obs[12:8], obs.d, exp_ev[12:8], exp_ev.d);
                end
            end
        end
        dv_p = data_valid;
        dr_p = data_ready;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push(input logic ld, pe, se, ov, bk, input logic [7:0] d);
        q.push_back({ld, pe, se, ov, bk, d});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge TX_CLK_TB);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int p, input logic spk);
        for (int c = 0; c < p; c++) begin
            rx_in = (spk && c == p / 2 + 1) ? ~b : b;
            @(posedge TX_CLK_TB);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic par_on, input logic pb,
                              input logic st1, input logic two, input logic st2, input int spike);
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, spike == i);
        if (par_on) drive_bit(pb, p, 1'b0);
        drive_bit(st1, p, 1'b0);
        if (two) drive_bit(st2, p, 1'b0);
        drive_bit(1'b1, p, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        prescale = 6'd8; data_ready = 1'b1;
        #3;
        chk("reset_p_data", 32'(p_data), 32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err_pulses", {29'b0, par_err, stp_err, overrun}, 32'h0);
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        // two plain frames
        push(1, 0, 0, 0, 0, 8'h99); send_frame(8'h99, 8, 0, 0, 1, 0, 0, -1);
        push(1, 0, 0, 0, 0, 8'h55); send_frame(8'h55, 8, 0, 0, 1, 0, 0, -1);
        // even parity: 0x99 has even weight so parity bit 1 is wrong
        par_en = 1'b1;
        push(0, 1, 0, 0, 0, 8'h55); send_frame(8'h99, 8, 1, 1, 1, 0, 0, -1);
        chk("par_err_no_valid", 32'(data_valid), 32'h0);
        push(1, 0, 0, 0, 0, 8'h55); send_frame(8'h55, 8, 1, 0, 1, 0, 0, -1);
        // two stop bits at P=16, second stop bad
        par_en = 1'b0; stop2 = 1'b1; prescale = 6'd16;
        push(0, 0, 1, 0, 0, 8'h55); send_frame(8'hA5, 16, 0, 0, 1, 1, 0, -1);
        chk("stp_err_no_valid", 32'(data_valid), 32'h0);
        push(1, 0, 0, 0, 0, 8'h3C); send_frame(8'h3C, 16, 0, 0, 1, 1, 1, -1);
        // overrun with consumer stalled
        stop2 = 1'b0; prescale = 6'd8; data_ready = 1'b0;
        push(1, 0, 0, 0, 0, 8'h12); send_frame(8'h12, 8, 0, 0, 1, 0, 0, -1);
        push(0, 0, 0, 1, 0, 8'h12); send_frame(8'h34, 8, 0, 0, 1, 0, 0, -1);
        chk("overrun_valid_held", 32'(data_valid), 32'h1);
        chk("overrun_p_data_kept", 32'(p_data), 32'h12);
        data_ready = 1'b1;
        @(negedge TX_CLK_TB);
        chk("ready_valid_before_edge", 32'(data_valid), 32'h1);
        @(negedge TX_CLK_TB);
        chk("ready_valid_cleared", 32'(data_valid), 32'h0);
        chk("p_data_held_after_clear", 32'(p_data), 32'h12);
        cycles(2);
        // 2-cycle start glitch
        rx_in = 1'b0; cycles(2); rx_in = 1'b1;
        cycles(2);
        chk("glitch_busy_in_start", 32'(busy), 32'h1);
        cycles(10);
        chk("glitch_busy_released", 32'(busy), 32'h0);
        // one-cycle spike in a 0 data bit, filtered by majority
        data_ready = 1'b0;
        push(1, 0, 0, 0, 0, 8'h96); send_frame(8'h96, 8, 0, 0, 1, 0, 0, 0);
        // reset in the middle of a frame
        drive_bit(1'b0, 8, 0); drive_bit(1'b0, 8, 0); drive_bit(1'b0, 8, 0);
        chk("busy_mid_frame", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midreset_p_data", 32'(p_data), 32'h0);
        chk("midreset_valid", 32'(data_valid), 32'h0);
        chk("midreset_busy", 32'(busy), 32'h0);
        rx_in = 1'b1;
        cycles(3);
        rst_n = 1'b1; data_ready = 1'b1;
        cycles(5);
        push(1, 0, 0, 0, 0, 8'hF0); send_frame(8'hF0, 8, 0, 0, 1, 0, 0, -1);
        // line held low for 12 bit times
`ifdef UART_RX_BREAK_DET_EN
        push(0, 0, 0, 0, 1, 8'hF0);
`else
        push(0, 0, 1, 0, 0, 8'hF0);
`endif
        rx_in = 1'b0; cycles(96);
        rx_in = 1'b1; cycles(4);
`ifdef UART_RX_BREAK_DET_EN
        chk("break_wait_busy", 32'(busy), 32'h1);
`else
        chk("framing_err_idle", 32'(busy), 32'h0);
`endif
        cycles(14);
        chk("after_break_idle", 32'(busy), 32'h0);
        push(1, 0, 0, 0, 0, 8'h3C); send_frame(8'h3C, 8, 0, 0, 1, 0, 0, -1);
        cycles(40);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
